lt24_pixel_bus_writer: RTL and testbench

//  Responder end of the pixel write interface (xAddr/yAddr/pixelData/pixelWrite/pixelReady) driven by game renderers.

---
 rtl/lt24_pkg.sv | 54 +++++
 rtl/lt24_pixel_bus_writer_if.sv | 19 +
 rtl/lt24_bus_strobe.sv | 64 ++++++
 rtl/lt24_pixel_bus_writer.sv | 145 ++++++++++++++
 tb/tb_lt24_pixel_bus_writer.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lt24_pkg.sv
// Shared types and constants for the LT24 pixel bus writer.
// Command opcodes, FSM encoding and the window word table.
package lt24_pkg;

  localparam int LT24_DEF_WIDTH  = 240;
  localparam int LT24_DEF_HEIGHT = 320;

  localparam logic [7:0] LT24_CMD_CASET = 8'h2A;
  localparam logic [7:0] LT24_CMD_PASET = 8'h2B;
  localparam logic [7:0] LT24_CMD_RAMWR = 8'h2C;

  localparam logic [3:0] WIN_WORDS = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WIN,
    ST_DATA
  } state_t;

  typedef struct packed {
    logic        rs;
    logic [15:0] data;
  } bus_word_t;

  function automatic bus_word_t win_word(
    input logic [3:0] idx,
    input logic [7:0] x,
    input logic [8:0] y,
    input logic [7:0] x_last,
    input logic [8:0] y_last
  );
    bus_word_t  w;
    logic [7:0] b;
    w.rs = 1'b1;
    b    = 8'h00;
    unique case (idx)
      4'd0:    begin w.rs = 1'b0; b = LT24_CMD_CASET; end
      4'd1:    b = 8'h00;
      4'd2:    b = x;
      4'd3:    b = 8'h00;
      4'd4:    b = x_last;
      4'd5:    begin w.rs = 1'b0; b = LT24_CMD_PASET; end
      4'd6:    b = {7'd0, y[8]};
      4'd7:    b = y[7:0];
      4'd8:    b = {7'd0, y_last[8]};
      4'd9:    b = y_last[7:0];
      4'd10:   begin w.rs = 1'b0; b = LT24_CMD_RAMWR; end
      default: b = 8'h00;
    endcase
    w.data = {8'h00, b};
    return w;
  endfunction

endpackage

// File: rtl/lt24_pixel_bus_writer_if.sv
// Pixel write handshake between a renderer and the LT24 writer.
// A transfer happens when pixelWrite and pixelReady are both high.
interface lt24_pixel_bus_writer_if;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;

  modport master (
    output xAddr, yAddr, pixelData, pixelWrite,
    input  pixelReady
  );

  modport slave (
    input  xAddr, yAddr, pixelData, pixelWrite,
    output pixelReady
  );
endinterface

// File: rtl/lt24_bus_strobe.sv
// One 8080-style bus word: Wr_n low phase then high phase.
// Holds Data/RS for the whole word; CS_n spans chained words.
module lt24_bus_strobe
  import lt24_pkg::*;
#(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  bus_word_t   i_word,
  output logic        o_done,
  output logic        o_wr_n,
  output logic        o_cs_n,
  output logic        o_rs,
  output logic [15:0] o_data
);

  localparam logic [7:0] LOW_LAST  = 8'(WR_LOW_CYCLES - 1);
  localparam logic [7:0] HIGH_LAST = 8'(WR_HIGH_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       r_high;
  logic       r_busy;

  assign o_done = r_busy & r_high & (r_cnt == HIGH_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_high <= 1'b0;
      r_busy <= 1'b0;
      o_wr_n <= 1'b1;
      o_cs_n <= 1'b1;
      o_rs   <= 1'b1;
      o_data <= '0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_high <= 1'b0;
      r_busy <= 1'b1;
      o_wr_n <= 1'b0;
      o_cs_n <= 1'b0;
      o_rs   <= i_word.rs;
      o_data <= i_word.data;
    end else if (r_busy) begin
      if (!r_high) begin
        if (r_cnt == LOW_LAST) begin
          r_high <= 1'b1;
          r_cnt  <= '0;
          o_wr_n <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else if (o_done) begin
        r_busy <= 1'b0;
        o_cs_n <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/lt24_pixel_bus_writer.sv
// Pixel handshake to LT24 bus: raster-order pixels cost one data
// word, anything else is preceded by a full CASET/PASET/RAMWR window.
module lt24_pixel_bus_writer
  import lt24_pkg::*;
#(
  parameter int LCD_WIDTH      = LT24_DEF_WIDTH,
  parameter int LCD_HEIGHT     = LT24_DEF_HEIGHT,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    resetApp,
  lt24_pixel_bus_writer_if.slave  pix,
  output logic                    addrError,
  output logic                    LT24Wr_n,
  output logic                    LT24Rd_n,
  output logic                    LT24CS_n,
  output logic                    LT24RS,
  output logic [15:0]             LT24Data
);

  localparam logic [7:0] X_LAST = 8'(LCD_WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(LCD_HEIGHT - 1);

  state_t      r_state;
  logic        r_ready;
  logic        r_err;
  logic [3:0]  r_idx;
  logic [7:0]  r_x;
  logic [8:0]  r_y;
  logic [15:0] r_pix;
  logic        r_next_valid;
  logic [7:0]  r_next_x;
  logic [8:0]  r_next_y;

  logic        w_accept;
  logic        w_in_range;
  logic        w_aligned;
  logic        w_start;
  logic        w_done;
  bus_word_t   w_word;

  assign pix.pixelReady = r_ready;
  assign addrError      = r_err;
  assign LT24Rd_n       = 1'b1;

  assign w_accept   = (r_state == ST_IDLE) & r_ready & pix.pixelWrite;
  assign w_in_range = (pix.xAddr <= X_LAST) & (pix.yAddr <= Y_LAST);
  assign w_aligned  = r_next_valid
                    & (pix.xAddr == r_next_x)
                    & (pix.yAddr == r_next_y);

  // First word is launched on the accept edge so Wr_n falls at N+1.
  always_comb begin
    w_start     = 1'b0;
    w_word.rs   = 1'b1;
    w_word.data = 16'h0000;
    if (w_accept && w_in_range) begin
      w_start = 1'b1;
      if (w_aligned) begin
        w_word.data = pix.pixelData;
      end else begin
        w_word = win_word(4'd0, pix.xAddr, pix.yAddr, X_LAST, Y_LAST);
      end
    end else if ((r_state == ST_WIN) && w_done) begin
      w_start = 1'b1;
      if (r_idx == WIN_WORDS) begin
        w_word.data = r_pix;
      end else begin
        w_word = win_word(r_idx, r_x, r_y, X_LAST, Y_LAST);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetApp) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_pix        <= '0;
      r_next_valid <= 1'b0;
      r_next_x     <= '0;
      r_next_y     <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_x   <= pix.xAddr;
            r_y   <= pix.yAddr;
            r_pix <= pix.pixelData;
            if (!w_in_range) begin
              r_err <= 1'b1;
            end else begin
              r_ready <= 1'b0;
              r_idx   <= 4'd1;
              r_state <= w_aligned ? ST_DATA : ST_WIN;
            end
          end
        end
        ST_WIN: begin
          if (w_done) begin
            if (r_idx == WIN_WORDS) r_state <= ST_DATA;
            else r_idx <= r_idx + 4'd1;
          end
        end
        ST_DATA: begin
          if (w_done) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_next_valid <= 1'b1;
            if (r_x == X_LAST) begin
              r_next_x <= '0;
              r_next_y <= (r_y == Y_LAST) ? '0 : r_y + 9'd1;
            end else begin
              r_next_x <= r_x + 8'd1;
              r_next_y <= r_y;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lt24_bus_strobe #(
    .WR_LOW_CYCLES  (WR_LOW_CYCLES),
    .WR_HIGH_CYCLES (WR_HIGH_CYCLES)
  ) u_strobe (
    .clk     (clock),
    .rst     (resetApp),
    .i_start (w_start),
    .i_word  (w_word),
    .o_done  (w_done),
    .o_wr_n  (LT24Wr_n),
    .o_cs_n  (LT24CS_n),
    .o_rs    (LT24RS),
    .o_data  (LT24Data)
  );

endmodule

// File: tb/tb_lt24_pixel_bus_writer.sv
// Bench for lt24_pixel_bus_writer: directed scenarios plus random
// pixels scored against a word-list model of the LCD protocol.
module tb_lt24_pixel_bus_writer;

  localparam int W = 240;
  localparam int H = 320;

  typedef logic [16:0] word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        addrError;
  logic        LT24Wr_n;
  logic        LT24Rd_n;
  logic        LT24CS_n;
  logic        LT24RS;
  logic [15:0] LT24Data;

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t exp_q[$];
  word_t log_q[$];
  bit    mon_chk = 1'b1;
  bit    m_valid;
  int    m_x;
  int    m_y;

  always #5 clk = ~clk;

  lt24_pixel_bus_writer_if pif ();

  lt24_pixel_bus_writer dut (
    .clock     (clk),
    .resetApp  (rst),
    .pix       (pif),
    .addrError (addrError),
    .LT24Wr_n  (LT24Wr_n),
    .LT24Rd_n  (LT24Rd_n),
    .LT24CS_n  (LT24CS_n),
    .LT24RS    (LT24RS),
    .LT24Data  (LT24Data)
  );

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: the words the LCD must see for one accepted pixel.
  task automatic model_pixel(input int x, input int y,
                             input logic [15:0] d,
                             output int eb, output bit ee);
    if (x >= W || y >= H) begin
      ee = 1'b1;
      eb = 0;
      return;
    end
    ee = 1'b0;
    if (!(m_valid && x == m_x && y == m_y)) begin
      exp_q.push_back({1'b0, 16'h002A});
      exp_q.push_back({1'b1, 16'h0000});
      exp_q.push_back({1'b1, 16'(x)});
      exp_q.push_back({1'b1, 16'h0000});
      exp_q.push_back({1'b1, 16'(W - 1)});
      exp_q.push_back({1'b0, 16'h002B});
      exp_q.push_back({1'b1, 16'(y / 256)});
      exp_q.push_back({1'b1, 16'(y % 256)});
      exp_q.push_back({1'b1, 16'((H - 1) / 256)});
      exp_q.push_back({1'b1, 16'((H - 1) % 256)});
      exp_q.push_back({1'b0, 16'h002C});
      eb = 12 * 4;
    end else begin
      eb = 4;
    end
    exp_q.push_back({1'b1, d});
    m_valid = 1'b1;
    m_x = x + 1;
    m_y = y;
    if (m_x == W) begin
      m_x = 0;
      m_y = y + 1;
      if (m_y == H) m_y = 0;
    end
  endtask

  task automatic monitor();
    bit    p_wr = 1'b1;
    int    low_run = 0;
    word_t cur = '0;
    word_t e;
    bit    fall;
    forever begin
      @(negedge clk);
      fall = (LT24Wr_n === 1'b0) && p_wr;
      if (fall) begin
        cur = {LT24RS, LT24Data};
        log_q.push_back(cur);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word_unexpected got=%h", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL bus_word got=%h exp=%h", cur, e);
          end
        end
        low_run = 1;
      end else if (LT24Wr_n === 1'b0) begin
        low_run++;
      end else if (!p_wr && mon_chk) begin
        n_tests++;
        if (low_run != 2) begin
          n_fail++;
          $display("FAIL low_phase got=%0d exp=2", low_run);
        end
      end
      if (mon_chk && LT24Wr_n === 1'b0 && LT24CS_n !== 1'b0) begin
        n_fail++;
        $display("FAIL cs_during_wr got=%b exp=0", LT24CS_n);
      end
      if (mon_chk && !fall && LT24CS_n === 1'b0 &&
          {LT24RS, LT24Data} !== cur) begin
        n_fail++;
        $display("FAIL word_stable got=%h exp=%h",
                 {LT24RS, LT24Data}, cur);
      end
      p_wr = (LT24Wr_n !== 1'b0);
    end
  endtask

  task automatic send_pixel(input int x, input int y,
                            input logic [15:0] d, input bit hold,
                            output int busy, output bit err,
                            output int eb, output bit ee);
    int t = 0;
    busy = -1;
    err  = 1'b0;
    eb   = 0;
    ee   = 1'b0;
    while (pif.pixelReady !== 1'b1) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout got=0 exp=1");
        return;
      end
    end
    pif.xAddr      = 8'(x);
    pif.yAddr      = 9'(y);
    pif.pixelData  = d;
    pif.pixelWrite = 1'b1;
    @(posedge clk);
    model_pixel(x, y, d, eb, ee);
    #1;
    if (!hold) pif.pixelWrite = 1'b0;
    @(negedge clk);
    err  = addrError;
    busy = 0;
    while (pif.pixelReady !== 1'b1) begin
      busy++;
      @(negedge clk);
      if (busy > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL busy_timeout got=%0d exp<=48", busy);
        return;
      end
    end
  endtask

  task automatic test_reset();
    pif.pixelWrite = 1'b0;
    pif.xAddr = '0;
    pif.yAddr = '0;
    pif.pixelData = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({pif.pixelReady, addrError} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready_err got=%b exp=00",
               {pif.pixelReady, addrError});
    end
    n_tests++;
    if ({LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS} !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_pins got=%b exp=1111",
               {LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS});
    end
    n_tests++;
    if (LT24Data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data got=%h exp=0000", LT24Data);
    end
    rst = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (pif.pixelReady !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset got=%b exp=1", pif.pixelReady);
    end
  endtask

  task automatic test_first_pixel();
    word_t ref_w [12] = '{17'h0002A, 17'h10000, 17'h10000, 17'h10000,
                          17'h100EF, 17'h0002B, 17'h10000, 17'h10000,
                          17'h10001, 17'h1003F, 17'h0002C, 17'h1F800};
    int b; bit e; int eb; bit ee;
    log_q.delete();
    send_pixel(0, 0, 16'hF800, 1'b0, b, e, eb, ee);
    n_tests++;
    if (b !== 48 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL first_busy got=%0d/%b exp=48/0", b, e);
    end
    n_tests++;
    if (log_q.size() != 12) begin
      n_fail++;
      $display("FAIL first_count got=%0d exp=12", log_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (log_q[i] !== ref_w[i]) begin
          n_fail++;
          $display("FAIL first_word%0d got=%h exp=%h",
                   i, log_q[i], ref_w[i]);
        end
      end
    end
  endtask

  task automatic test_aligned_next();
    int b; bit e; int eb; bit ee;
    log_q.delete();
    send_pixel(1, 0, 16'h07E0, 1'b0, b, e, eb, ee);
    n_tests++;
    if (b !== 4 || log_q.size() != 1) begin
      n_fail++;
      $display("FAIL aligned_busy got=%0d/%0d exp=4/1",
               b, log_q.size());
    end else if (log_q[0] !== 17'h107E0) begin
      n_fail++;
      $display("FAIL aligned_word got=%h exp=107e0", log_q[0]);
    end
  endtask

  task automatic test_raster_row();
    int b; bit e; int eb; bit ee;
    int y0 = $urandom_range(1, H - 3);
    int bad = 0;
    int wins = 0;
    send_pixel(0, y0, 16'($urandom), 1'b0, b, e, eb, ee);
    for (int i = 1; i < W + 4; i++) begin
      send_pixel(i % W, y0 + i / W, 16'($urandom), 1'b1,
                 b, e, eb, ee);
      if (b !== 4 || e !== 1'b0) bad++;
      if (b == 48) wins++;
    end
    pif.pixelWrite = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL raster_row got=%0d_bad/%0d_win exp=0/0",
               bad, wins);
    end
  endtask

  task automatic test_frame_wrap();
    int b; bit e; int eb; bit ee;
    int bad = 0;
    send_pixel(236, H - 1, 16'h1234, 1'b0, b, e, eb, ee);
    for (int i = 237; i < W + 3; i++) begin
      send_pixel(i % W, (i < W) ? H - 1 : 0, 16'($urandom), 1'b1,
                 b, e, eb, ee);
      if (b !== 4) bad++;
    end
    pif.pixelWrite = 1'b0;
    n_tests++;
    if (bad != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_wrap got=%0d_bad/%0d_left exp=0/0",
               bad, exp_q.size());
    end
  endtask

  task automatic test_jump();
    int b; bit e; int eb; bit ee;
    send_pixel(0, 0, 16'hAAAA, 1'b0, b, e, eb, ee);
    log_q.delete();
    send_pixel(5, 5, 16'h5555, 1'b0, b, e, eb, ee);
    n_tests++;
    if (b !== 48 || log_q.size() != 12) begin
      n_fail++;
      $display("FAIL jump_busy got=%0d/%0d exp=48/12", b, log_q.size());
    end else if (log_q[2] !== 17'h10005 || log_q[6] !== 17'h10000 ||
                 log_q[7] !== 17'h10005 || log_q[11] !== 17'h15555) begin
      n_fail++;
      $display("FAIL jump_words got=%h,%h,%h,%h exp=10005,10000,10005,15555",
               log_q[2], log_q[6], log_q[7], log_q[11]);
    end
  endtask

  task automatic test_addr_error();
    int b; bit e; int eb; bit ee;
    log_q.delete();
    send_pixel(240, 10, 16'hBEEF, 1'b0, b, e, eb, ee);
    n_tests++;
    if (b !== 0 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL err_x got=%0d/%b exp=0/1", b, e);
    end
    @(negedge clk);
    n_tests++;
    if (addrError !== 1'b0 || log_q.size() != 0) begin
      n_fail++;
      $display("FAIL err_pulse got=%b/%0d exp=0/0",
               addrError, log_q.size());
    end
    send_pixel(3, 400, 16'hBEEF, 1'b0, b, e, eb, ee);
    n_tests++;
    if (b !== 0 || e !== 1'b1) begin
      n_fail++;
      $display("FAIL err_y got=%0d/%b exp=0/1", b, e);
    end
    send_pixel(6, 5, 16'h0F0F, 1'b0, b, e, eb, ee);
    n_tests++;
    if (b !== 4 || e !== 1'b0 || log_q.size() != 1) begin
      n_fail++;
      $display("FAIL err_then_aligned got=%0d/%b/%0d exp=4/0/1",
               b, e, log_q.size());
    end
  endtask

  task automatic test_random();
    int b; bit e; int eb; bit ee;
    int x; int y; int r;
    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4 && m_valid) begin
        x = m_x;
        y = m_y;
      end else if (r < 8) begin
        x = $urandom_range(0, W - 1);
        y = $urandom_range(0, H - 1);
      end else begin
        x = $urandom_range(W, 255);
        y = $urandom_range(0, 511);
      end
      send_pixel(x, y, 16'($urandom), 1'($urandom_range(0, 1)),
                 b, e, eb, ee);
      n_tests++;
      if (b !== eb || e !== ee) begin
        n_fail++;
        $display("FAIL random%0d (%0d,%0d) got=%0d/%b exp=%0d/%b",
                 i, x, y, b, e, eb, ee);
      end
    end
    pif.pixelWrite = 1'b0;
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int b; bit e; int eb; bit ee;
    int t = 0;
    int x = (m_valid && m_x == 100 && m_y == 200) ? 101 : 100;
    pif.xAddr      = 8'(x);
    pif.yAddr      = 9'd200;
    pif.pixelData  = 16'hCAFE;
    pif.pixelWrite = 1'b1;
    @(posedge clk);
    model_pixel(x, 200, 16'hCAFE, eb, ee);
    #1 pif.pixelWrite = 1'b0;
    log_q.delete();
    mon_chk = 1'b0;
    while (log_q.size() < 7 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (log_q.size() != 7 || LT24Wr_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_word6 got=%0d/%b exp=7/0",
               log_q.size(), LT24Wr_n);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({LT24Wr_n, LT24CS_n, LT24RS, pif.pixelReady} !== 4'b1110 ||
        LT24Data !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset got=%b/%h exp=1110/0000",
               {LT24Wr_n, LT24CS_n, LT24RS, pif.pixelReady}, LT24Data);
    end
    @(negedge clk);
    mon_chk = 1'b1;
    log_q.delete();
    send_pixel(1, 0, 16'h0001, 1'b0, b, e, eb, ee);
    n_tests++;
    if (b !== 48 || log_q.size() != 12) begin
      n_fail++;
      $display("FAIL mid_after got=%0d/%0d exp=48/12", b, log_q.size());
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_first_pixel();
    test_aligned_next();
    test_raster_row();
    test_frame_wrap();
    test_jump();
    test_addr_error();
    test_random();
    test_reset_mid();
    repeat (4) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_left got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
